// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants, state encodings and entry type for the fetch unit
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define INST_NOP            32'h0000_0013
`define IF_FETCH_XLEN       32
`define IF_FETCH_RESET_ADDR 32'h0000_0000
`endif

package if_fetch_pkg;

    localparam int BUS_W = `IF_FETCH_XLEN;

    localparam logic [BUS_W-1:0] INST_NOP = `INST_NOP;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT
    } state_t;

    // One queue slot: fetched word plus the address it came from
    typedef struct packed {
        logic [BUS_W-1:0] inst;
        logic [BUS_W-1:0] addr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary
    function automatic logic [BUS_W-1:0] word_align(input logic [BUS_W-1:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction bus req/gnt/rvalid interface
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic             req;
    logic [BUS_W-1:0] addr;
    logic             gnt;
    logic             rvalid;
    logic [BUS_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - two-entry fetch queue with flush
module if_fetch_buf
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic [1:0]   cnt;

    // entry0 is always the head; a pop shifts entry1 down, flush wins over push/pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        entry0 <= push_data;
                        cnt    <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        entry1 <= push_data;
                        cnt    <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        entry0 <= entry1;
                        cnt    <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd0) begin
                        entry0 <= push_data;
                        cnt    <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = entry0;
    assign count = cnt;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch unit feeding the IF/ID register
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = `IF_FETCH_RESET_ADDR,
    parameter int          XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_flag_i,
    input  logic            jump_flag_i,
    input  logic [XLEN-1:0] jump_addr_i,
    if_fetch_if.master      ibus,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            inst_valid_o
);

    state_t       state;
    state_t       state_nx;
    logic [31:0]  pc;
    logic [31:0]  pc_nx;
    logic [31:0]  req_addr;
    logic [31:0]  req_addr_nx;
    logic         kill;
    logic         kill_nx;
    logic         req;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_data;

    // State, pc, outstanding address and kill flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_ADDR;
            req_addr <= RESET_ADDR;
            kill     <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
            kill     <= kill_nx;
        end
    end

    // Next-state, request and push decode; a jump overrides pc and suppresses push/request
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        kill_nx     = kill;
        req         = 1'b0;
        push        = 1'b0;
        case (state)
            S_IDLE: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                // Only issue while a slot is guaranteed free for the response
                req = (count < 2'd2) && !jump_flag_i;
                if (req && ibus.gnt) begin
                    req_addr_nx = pc;
                    state_nx    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ibus.rvalid) begin
                    state_nx = S_REQ;
                    kill_nx  = 1'b0;
                    if (!kill && !jump_flag_i) begin
                        push  = 1'b1;
                        pc_nx = req_addr + 32'd4;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (jump_flag_i) begin
            pc_nx = word_align(jump_addr_i);
            // The response still in flight belongs to the old stream
            if (state == S_WAIT && !ibus.rvalid) begin
                kill_nx = 1'b1;
            end
        end
    end

    assign pop       = (count != 2'd0) && !hold_flag_i;
    assign push_data = '{inst: ibus.rdata, addr: req_addr};

    if_fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (jump_flag_i),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    assign ibus.req     = req;
    assign ibus.addr    = pc;
    assign inst_valid_o = (count != 2'd0);
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.addr : 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jaddr = 32'd0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    if_fetch_if ibus ();

    if_fetch #(.RESET_ADDR(32'h0000_0000), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_flag_i  (hold),
        .jump_flag_i  (jump),
        .jump_addr_i  (jaddr),
        .ibus         (ibus),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid)
    );

    always #5 clk = ~clk;

    // bus slave model
    logic        gnt_en = 1'b1;
    int          lat = 0;
    logic        stale_next = 1'b0;
    logic        pend = 1'b0;
    logic        pend_stale = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_cnt = 0;
    logic [31:0] grants[$];
    logic [31:0] expq[$];
    logic        seen_beef = 1'b0;

    // values sampled mid-cycle by cycle()
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_iaddr;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        hold;
        logic        e_req;
        logic [31:0] e_baddr;
        logic        e_valid;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] grant_at(input int i);
        if (grants.size() > i) return grants[i];
        return 32'hFFFF_FFF1;
    endfunction

    // One clock: present response, grant, sample, score consumption, advance
    task automatic cycle();
        logic [31:0] e;
        logic        g;
        logic        rv;
        logic [31:0] a;
        ibus.rvalid = pend && (pend_cnt == 0);
        ibus.rdata  = pend_stale ? 32'hDEAD_BEEF : mem_word(pend_addr);
        #1;
        ibus.gnt = gnt_en && ibus.req && !pend;
        #1;
        s_req   = ibus.req;
        s_addr  = ibus.addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_iaddr = inst_addr;
        if (inst_valid && inst == 32'hDEAD_BEEF) seen_beef = 1'b1;
        if (rst && inst_valid && !hold && !jump) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_consume: got addr %h expected none", inst_addr);
            end else begin
                e = expq.pop_front();
                chk("consume_addr", inst_addr, e);
                chk("consume_inst", inst, mem_word(e));
            end
        end
        g  = ibus.gnt;
        rv = ibus.rvalid;
        a  = ibus.addr;
        @(posedge clk);
        if (rv) pend = 1'b0;
        else if (pend && pend_cnt > 0) pend_cnt--;
        if (g) begin
            pend       = 1'b1;
            pend_addr  = a;
            pend_cnt   = lat;
            pend_stale = stale_next;
            grants.push_back(a);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; hold = 1'b0; jump = 1'b0;
        gnt_en = 1'b0; lat = 0; stale_next = 1'b0;
        cycle();
        cycle();
        pend = 1'b0; pend_cnt = 0; pend_stale = 1'b0;
        rst = 1'b1; gnt_en = 1'b1;
        expq.delete(); grants.delete(); seen_beef = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (expq.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(name, expq.size(), 0);
        hold = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.rdata = 32'd0;

        tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h8};

        // reset state
        do_reset();
        chk("rst_req", ibus.req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, `INST_NOP);
        chk("rst_iaddr", inst_addr, 32'h0);

        // basic stream, table driven
        expq.push_back(32'h0); expq.push_back(32'h4); expq.push_back(32'h8);
        for (int i = 0; i < 8; i++) begin
            hold = tbl[i].hold;
            cycle();
            chk($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_baddr", i), s_addr, tbl[i].e_baddr);
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_iaddr", i), s_iaddr, tbl[i].e_iaddr);
            chk($sformatf("tbl%0d_inst", i), s_inst,
                tbl[i].e_valid ? mem_word(tbl[i].e_iaddr) : `INST_NOP);
        end
        chk("basic_drain", expq.size(), 0);

        // hold with full queue
        do_reset();
        expq.push_back(32'h0); expq.push_back(32'h4); expq.push_back(32'h8);
        cycle(); cycle(); cycle();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i >= 2) chk("hold_req_off", s_req, 1'b0);
            chk("hold_iaddr", s_iaddr, 32'h0);
            chk("hold_inst", s_inst, mem_word(32'h0));
        end
        hold = 1'b0;
        drain("hold_drain", 40);

        // jump while waiting: stale response dropped
        do_reset();
        hold = 1'b1;
        cycle(); cycle(); cycle();
        lat = 3; stale_next = 1'b1;
        cycle();
        chk("jw_req4", s_req, 1'b1);
        chk("jw_addr4", s_addr, 32'h4);
        lat = 0; stale_next = 1'b0;
        jump = 1'b1; jaddr = 32'h103;
        cycle();
        chk("jw_req_jump", s_req, 1'b0);
        jump = 1'b0; hold = 1'b0;
        grants.delete();
        expq.push_back(32'h100); expq.push_back(32'h104);
        cycle();
        chk("jw_flush_valid", s_valid, 1'b0);
        chk("jw_flush_inst", s_inst, `INST_NOP);
        chk("jw_flush_iaddr", s_iaddr, 32'h0);
        drain("jw_drain", 40);
        chk("jw_first_req", grant_at(0), 32'h100);
        chk("jw_no_stale", seen_beef, 1'b0);

        // jump in the request cycle for 0x8
        do_reset();
        expq.push_back(32'h0); expq.push_back(32'h40); expq.push_back(32'h44);
        n = 0;
        while (!(ibus.req && ibus.addr == 32'h8) && n < 20) begin
            cycle();
            n++;
        end
        chk("jg_reach8", ibus.addr, 32'h8);
        grants.delete();
        jump = 1'b1; jaddr = 32'h40;
        cycle();
        chk("jg_req_jump", s_req, 1'b0);
        jump = 1'b0;
        drain("jg_drain", 40);
        chk("jg_first_req", grant_at(0), 32'h40);

        // grant withheld
        do_reset();
        expq.push_back(32'h0);
        gnt_en = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("gw_req", s_req, 1'b1);
            chk("gw_addr", s_addr, 32'h0);
        end
        gnt_en = 1'b1;
        drain("gw_drain", 20);
        chk("gw_grant0", grant_at(0), 32'h0);
        cycle(); cycle(); cycle();

        // pc wrap
        do_reset();
        cycle();
        jump = 1'b1; jaddr = 32'hFFFF_FFFE;
        cycle();
        jump = 1'b0;
        expq.push_back(32'hFFFF_FFFC); expq.push_back(32'h0);
        drain("wrap_drain", 40);
        chk("wrap_req0", grant_at(0), 32'hFFFF_FFFC);
        chk("wrap_req1", grant_at(1), 32'h0);

        // reset while waiting; late response ignored
        do_reset();
        lat = 1; stale_next = 1'b1;
        cycle(); cycle();
        lat = 0; stale_next = 1'b0;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("rw_req", ibus.req, 1'b0);
        chk("rw_valid", inst_valid, 1'b0);
        chk("rw_inst", inst, `INST_NOP);
        chk("rw_iaddr", inst_addr, 32'h0);
        grants.delete();
        expq.push_back(32'h0);
        drain("rw_drain", 20);
        chk("rw_first_req", grant_at(0), 32'h0);
        chk("rw_no_stale", seen_beef, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
